// File: rtl/rv32im_lsu.sv
// rv32im_lsu -- load/store unit sitting directly downstream of rv32im_exu.
//
// Takes one memory operation at a time from the EXU (opcode, byte address,
// right-justified store data), runs a request/grant/response transaction on
// the data-memory bus, and returns aligned, sign/zero-extended load data on
// a valid/ready response port. Stores and errors return zero data.
//
// Ports:
//   clk_i, rst_n_i          clock (rising edge), async active-low reset
//   lsu_opcode_i            `LSU_OPCODE_* operation
//   addr_i, wdata_i         byte address and store data from the EXU
//   req_valid_i/req_ready_o request handshake (ready only while idle)
//   mem_req_o, mem_we_o     bus request and write strobe
//   mem_be_o, mem_addr_o    byte enables and word-aligned address
//   mem_wdata_o             lane-replicated store data
//   mem_gnt_i, mem_rvalid_i bus grant and read-data valid
//   mem_rdata_i             read word from the bus
//   rsp_valid_o/rsp_ready_i response handshake
//   rsp_data_o, rsp_err_o   load result, bus-timeout flag
//   misalign_o              misaligned-access trap flag
//
// Parameter BUS_TIMEOUT: cycles tolerated in REQ or WAIT before aborting
// with rsp_err_o; 0 disables the timeout.
//
// Optional build macro LSU_MISALIGN_TRAP_EN: when defined, misaligned
// halfword/word accesses skip the bus and respond with misalign_o = 1. When
// undefined, misalign_o is tied low and the offending low address bits are
// forced to natural alignment.
//
// The datapath assumes `API_DATA_WIDTH = 32 (four byte lanes).

`ifndef API_DATA_WIDTH
`define API_DATA_WIDTH 32
`endif

`ifndef LSU_OPCODE_WIDTH
`define LSU_OPCODE_WIDTH 4
`endif

`ifndef LSU_OPCODE_NONE
`define LSU_OPCODE_NONE 4'd0
`define LSU_OPCODE_LB   4'd1
`define LSU_OPCODE_LH   4'd2
`define LSU_OPCODE_LW   4'd3
`define LSU_OPCODE_LBU  4'd4
`define LSU_OPCODE_LHU  4'd5
`define LSU_OPCODE_SB   4'd6
`define LSU_OPCODE_SH   4'd7
`define LSU_OPCODE_SW   4'd8
`endif

module rv32im_lsu #(
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic [`LSU_OPCODE_WIDTH-1:0]  lsu_opcode_i,
    input  logic [`API_DATA_WIDTH-1:0]    addr_i,
    input  logic [`API_DATA_WIDTH-1:0]    wdata_i,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    output logic                          mem_req_o,
    output logic                          mem_we_o,
    output logic [3:0]                    mem_be_o,
    output logic [`API_DATA_WIDTH-1:0]    mem_addr_o,
    output logic [`API_DATA_WIDTH-1:0]    mem_wdata_o,
    input  logic                          mem_gnt_i,
    input  logic                          mem_rvalid_i,
    input  logic [`API_DATA_WIDTH-1:0]    mem_rdata_i,
    output logic                          rsp_valid_o,
    input  logic                          rsp_ready_i,
    output logic [`API_DATA_WIDTH-1:0]    rsp_data_o,
    output logic                          rsp_err_o,
    output logic                          misalign_o
);

    localparam int DW = `API_DATA_WIDTH;
    localparam int OW = `LSU_OPCODE_WIDTH;

    // Counter only has to reach BUS_TIMEOUT-1: the timeout fires in the cycle
    // that completes the BUS_TIMEOUT-th cycle spent in REQ or WAIT.
    localparam int CNT_W = (BUS_TIMEOUT < 2) ? 1 : $clog2(BUS_TIMEOUT);
    localparam logic [CNT_W-1:0] TO_LAST =
        CNT_W'((BUS_TIMEOUT == 0) ? 0 : BUS_TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    state_t          state_q, state_d;
    logic [OW-1:0]   op_q, op_d;
    logic [1:0]      off_q, off_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            req_ready_d, mem_req_d, mem_we_d;
    logic [3:0]      mem_be_d;
    logic [DW-1:0]   mem_addr_d, mem_wdata_d, rsp_data_d;
    logic            rsp_valid_d, rsp_err_d;
    logic            mis_q, mis_d;

    // ---------------- request decode (IDLE side) ----------------
    logic            in_byte, in_half, in_word, in_store, in_ok, trap;
    logic [1:0]      off_in;
    logic [3:0]      be_in;
    logic [DW-1:0]   wdata_in;

    // NOTE: every variable assigned in an always_comb gets a default first;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        in_byte  = 1'b0;
        in_half  = 1'b0;
        in_word  = 1'b0;
        in_store = 1'b0;
        case (lsu_opcode_i)
            `LSU_OPCODE_LB, `LSU_OPCODE_LBU: in_byte = 1'b1;
            `LSU_OPCODE_LH, `LSU_OPCODE_LHU: in_half = 1'b1;
            `LSU_OPCODE_LW:                  in_word = 1'b1;
            `LSU_OPCODE_SB: begin in_byte = 1'b1; in_store = 1'b1; end
            `LSU_OPCODE_SH: begin in_half = 1'b1; in_store = 1'b1; end
            `LSU_OPCODE_SW: begin in_word = 1'b1; in_store = 1'b1; end
            default: ;
        endcase
    end

    // NONE and unassigned encodings are not accepted.
    assign in_ok = in_byte | in_half | in_word;

    // Natural alignment applied to the offset; only matters when the trap is
    // not built, since a trapped access never reaches the bus.
    assign off_in = in_word ? 2'b00 : (in_half ? {addr_i[1], 1'b0} : addr_i[1:0]);

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = (in_half & addr_i[0]) | (in_word & (addr_i[1:0] != 2'b00));
`else
    assign trap = 1'b0;
`endif

    always_comb begin
        be_in    = 4'b0000;
        wdata_in = wdata_i;
        if (in_store) begin
            if (in_byte) begin
                be_in    = 4'b0001 << off_in;
                wdata_in = {4{wdata_i[7:0]}};
            end else if (in_half) begin
                be_in    = 4'b0011 << off_in;
                wdata_in = {2{wdata_i[15:0]}};
            end else begin
                be_in    = 4'b1111;
            end
        end
    end

    // ---------------- load extraction (WAIT side) ----------------
    logic [DW-1:0] lane, load_data;

    assign lane = mem_rdata_i >> {off_q, 3'b000};

    always_comb begin
        case (op_q)
            `LSU_OPCODE_LB:  load_data = {{24{lane[7]}}, lane[7:0]};
            `LSU_OPCODE_LBU: load_data = {24'd0, lane[7:0]};
            `LSU_OPCODE_LH:  load_data = {{16{lane[15]}}, lane[15:0]};
            `LSU_OPCODE_LHU: load_data = {16'd0, lane[15:0]};
            default:         load_data = lane;
        endcase
    end

    logic timeout_hit;
    assign timeout_hit = (BUS_TIMEOUT != 0) && (cnt_q == TO_LAST);

    // ---------------- next state / next outputs ----------------
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        off_d       = off_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_o;
        mem_we_d    = mem_we_o;
        mem_be_d    = mem_be_o;
        mem_addr_d  = mem_addr_o;
        mem_wdata_d = mem_wdata_o;
        rsp_valid_d = rsp_valid_o;
        rsp_data_d  = rsp_data_o;
        rsp_err_d   = rsp_err_o;
        mis_d       = mis_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid_i && in_ok) begin
                    op_d  = lsu_opcode_i;
                    off_d = off_in;
                    if (trap) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = '0;
                        rsp_err_d   = 1'b0;
                        mis_d       = 1'b1;
                    end else begin
                        state_d     = S_REQ;
                        cnt_d       = '0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = in_store;
                        mem_be_d    = be_in;
                        mem_addr_d  = {addr_i[DW-1:2], 2'b00};
                        mem_wdata_d = wdata_in;
                    end
                end
            end
            S_REQ: begin
                // Grant takes priority over a timeout in the same cycle.
                if (mem_gnt_i) begin
                    mem_req_d = 1'b0;
                    cnt_d     = '0;
                    if (mem_we_o) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = '0;
                        rsp_err_d   = 1'b0;
                    end else begin
                        state_d = S_WAIT;
                    end
                end else if (timeout_hit) begin
                    mem_req_d   = 1'b0;
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (mem_rvalid_i) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = load_data;
                    rsp_err_d   = 1'b0;
                end else if (timeout_hit) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_data_d  = '0;
                    rsp_err_d   = 1'b0;
                    mis_d       = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        req_ready_d = (state_d == S_IDLE);
    end

    // ---------------- registers ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            op_q        <= `LSU_OPCODE_NONE;
            off_q       <= 2'b00;
            cnt_q       <= '0;
            req_ready_o <= 1'b1;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_be_o    <= 4'b0000;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
            rsp_err_o   <= 1'b0;
            mis_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            off_q       <= off_d;
            cnt_q       <= cnt_d;
            req_ready_o <= req_ready_d;
            mem_req_o   <= mem_req_d;
            mem_we_o    <= mem_we_d;
            mem_be_o    <= mem_be_d;
            mem_addr_o  <= mem_addr_d;
            mem_wdata_o <= mem_wdata_d;
            rsp_valid_o <= rsp_valid_d;
            rsp_data_o  <= rsp_data_d;
            rsp_err_o   <= rsp_err_d;
            mis_q       <= mis_d;
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign_o = mis_q;
`else
    assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_rv32im_lsu.sv
// Testbench for rv32im_lsu (BUS_TIMEOUT = 4). Directed scenarios with
// hand-computed expectations; the misaligned scenario follows whichever
// build of LSU_MISALIGN_TRAP_EN is compiled.

`ifndef API_DATA_WIDTH
`define API_DATA_WIDTH 32
`endif

`ifndef LSU_OPCODE_WIDTH
`define LSU_OPCODE_WIDTH 4
`endif

`ifndef LSU_OPCODE_NONE
`define LSU_OPCODE_NONE 4'd0
`define LSU_OPCODE_LB   4'd1
`define LSU_OPCODE_LH   4'd2
`define LSU_OPCODE_LW   4'd3
`define LSU_OPCODE_LBU  4'd4
`define LSU_OPCODE_LHU  4'd5
`define LSU_OPCODE_SB   4'd6
`define LSU_OPCODE_SH   4'd7
`define LSU_OPCODE_SW   4'd8
`endif

module tb_rv32im_lsu;

    localparam int OW = `LSU_OPCODE_WIDTH;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [OW-1:0] lsu_opcode = `LSU_OPCODE_NONE;
    logic [31:0]   addr = '0;
    logic [31:0]   wdata = '0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          mem_req, mem_we;
    logic [3:0]    mem_be;
    logic [31:0]   mem_addr, mem_wdata;
    logic          mem_gnt = 1'b0;
    logic          mem_rvalid = 1'b0;
    logic [31:0]   mem_rdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [31:0]   rsp_data;
    logic          rsp_err;
    logic          misalign;

    int n_checks = 0;
    int n_fail   = 0;

    rv32im_lsu #(.BUS_TIMEOUT(4)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .lsu_opcode_i (lsu_opcode),
        .addr_i       (addr),
        .wdata_i      (wdata),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_be_o     (mem_be),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_gnt_i    (mem_gnt),
        .mem_rvalid_i (mem_rvalid),
        .mem_rdata_i  (mem_rdata),
        .rsp_valid_o  (rsp_valid),
        .rsp_ready_i  (rsp_ready),
        .rsp_data_o   (rsp_data),
        .rsp_err_o    (rsp_err),
        .misalign_o   (misalign)
    );

    always #5 clk = ~clk;

    // Advance one cycle; inputs driven and outputs sampled 1 unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request in the current cycle (cycle 0); returns in cycle 1.
    task automatic issue(input logic [OW-1:0] op, input logic [31:0] a, input logic [31:0] d);
        lsu_opcode = op;
        addr       = a;
        wdata      = d;
        req_valid  = 1'b1;
        tick();
        req_valid  = 1'b0;
        lsu_opcode = `LSU_OPCODE_NONE;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({req_ready, mem_req, mem_we, rsp_valid, rsp_err, misalign} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 100000",
                     {req_ready, mem_req, mem_we, rsp_valid, rsp_err, misalign});
        end
        n_checks++;
        if ({mem_be, mem_addr, mem_wdata, rsp_data} !== '0) begin
            n_fail++;
            $display("FAIL reset_buses: be=%b addr=%h wdata=%h rdata=%h expected all 0",
                     mem_be, mem_addr, mem_wdata, rsp_data);
        end
    endtask

    task automatic test_none_ignored();
        lsu_opcode = `LSU_OPCODE_NONE;
        req_valid  = 1'b1;
        tick();
        tick();
        req_valid  = 1'b0;
        n_checks++;
        if ({req_ready, mem_req, rsp_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL none_ignored: got %b expected 100", {req_ready, mem_req, rsp_valid});
        end
    endtask

    task automatic test_sw();
        issue(`LSU_OPCODE_SW, 32'h0000_0100, 32'hDEAD_BEEF);
        // cycle 1
        n_checks++;
        if ({req_ready, mem_req, mem_we} !== 3'b011) begin
            n_fail++;
            $display("FAIL sw_req: got %b expected 011", {req_ready, mem_req, mem_we});
        end
        n_checks++;
        if ({mem_be, mem_addr, mem_wdata} !== {4'b1111, 32'h0000_0100, 32'hDEAD_BEEF}) begin
            n_fail++;
            $display("FAIL sw_bus: be=%b addr=%h wdata=%h expected 1111 00000100 deadbeef",
                     mem_be, mem_addr, mem_wdata);
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        // cycle 2
        n_checks++;
        if ({rsp_valid, rsp_err, mem_req, rsp_data} !== {3'b100, 32'h0}) begin
            n_fail++;
            $display("FAIL sw_rsp: valid=%b err=%b req=%b data=%h expected 1 0 0 0",
                     rsp_valid, rsp_err, mem_req, rsp_data);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_checks++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL sw_done: got %b expected 01", {rsp_valid, req_ready});
        end
    endtask

    task automatic test_sb_sh();
        issue(`LSU_OPCODE_SB, 32'h0000_0103, 32'h0000_00A5);
        // grant withheld two cycles: bus fields must stay stable
        tick();
        tick();
        n_checks++;
        if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !==
            {2'b11, 4'b1000, 32'h0000_0100, 32'hA5A5_A5A5}) begin
            n_fail++;
            $display("FAIL sb_bus: req=%b we=%b be=%b addr=%h wdata=%h expected 1 1 1000 00000100 a5a5a5a5",
                     mem_req, mem_we, mem_be, mem_addr, mem_wdata);
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        issue(`LSU_OPCODE_SH, 32'h0000_0202, 32'h1234_BEEF);
        n_checks++;
        if ({mem_be, mem_addr, mem_wdata} !== {4'b1100, 32'h0000_0200, 32'hBEEF_BEEF}) begin
            n_fail++;
            $display("FAIL sh_bus: be=%b addr=%h wdata=%h expected 1100 00000200 beefbeef",
                     mem_be, mem_addr, mem_wdata);
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_loads();
        logic [OW-1:0] ops  [6];
        logic [31:0]   adrs [6];
        logic [31:0]   rds  [6];
        logic [31:0]   exps [6];
        ops[0] = `LSU_OPCODE_LB;  adrs[0] = 32'h102; rds[0] = 32'h1180_2233; exps[0] = 32'hFFFF_FF80;
        ops[1] = `LSU_OPCODE_LBU; adrs[1] = 32'h102; rds[1] = 32'h1180_2233; exps[1] = 32'h0000_0080;
        ops[2] = `LSU_OPCODE_LHU; adrs[2] = 32'h102; rds[2] = 32'h1180_2233; exps[2] = 32'h0000_1180;
        ops[3] = `LSU_OPCODE_LH;  adrs[3] = 32'h100; rds[3] = 32'h1180_F234; exps[3] = 32'hFFFF_F234;
        ops[4] = `LSU_OPCODE_LB;  adrs[4] = 32'h101; rds[4] = 32'h1180_2233; exps[4] = 32'h0000_0022;
        ops[5] = `LSU_OPCODE_LW;  adrs[5] = 32'h104; rds[5] = 32'hCAFE_F00D; exps[5] = 32'hCAFE_F00D;
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], adrs[i], 32'hFFFF_FFFF);
            // cycle 1: REQ; a stray rvalid here must be ignored
            n_checks++;
            if ({mem_req, mem_we, mem_be, mem_addr} !== {2'b10, 4'b0000, {adrs[i][31:2], 2'b00}}) begin
                n_fail++;
                $display("FAIL load%0d_req: req=%b we=%b be=%b addr=%h", i, mem_req, mem_we, mem_be, mem_addr);
            end
            mem_gnt    = 1'b1;
            mem_rvalid = 1'b1;
            mem_rdata  = 32'h5555_5555;
            tick();
            mem_gnt    = 1'b0;
            mem_rdata  = rds[i];
            // cycle 2: WAIT, real read data
            n_checks++;
            if ({mem_req, rsp_valid} !== 2'b00) begin
                n_fail++;
                $display("FAIL load%0d_wait: req=%b rsp_valid=%b expected 0 0", i, mem_req, rsp_valid);
            end
            tick();
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h0;
            // cycle 3
            n_checks++;
            if ({rsp_valid, rsp_err, rsp_data} !== {2'b10, exps[i]}) begin
                n_fail++;
                $display("FAIL load%0d_data: valid=%b err=%b data=%h expected 1 0 %h",
                         i, rsp_valid, rsp_err, rsp_data, exps[i]);
            end
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_timeout();
        issue(`LSU_OPCODE_LW, 32'h0000_0200, 32'h0);
        for (int c = 1; c <= 4; c++) begin
            n_checks++;
            if ({mem_req, rsp_valid} !== 2'b10) begin
                n_fail++;
                $display("FAIL timeout_req_c%0d: req=%b rsp_valid=%b expected 1 0", c, mem_req, rsp_valid);
            end
            tick();
        end
        // cycle 5 onward: error response held while rsp_ready stays low
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if ({mem_req, rsp_valid, rsp_err, rsp_data} !== {3'b011, 32'h0}) begin
                n_fail++;
                $display("FAIL timeout_rsp_h%0d: req=%b valid=%b err=%b data=%h expected 0 1 1 0",
                         c, mem_req, rsp_valid, rsp_err, rsp_data);
            end
            if (c < 3) tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_checks++;
        if ({rsp_valid, rsp_err, req_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL timeout_done: got %b expected 001", {rsp_valid, rsp_err, req_ready});
        end
    endtask

    task automatic test_timeout_race();
        issue(`LSU_OPCODE_LW, 32'h0000_0300, 32'h0);
        tick();
        tick();
        tick();
        // cycle 4: grant in the same cycle the timeout would fire
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        n_checks++;
        if ({mem_req, rsp_valid, rsp_err} !== 3'b000) begin
            n_fail++;
            $display("FAIL race_gnt_wins: req=%b valid=%b err=%b expected 0 0 0", mem_req, rsp_valid, rsp_err);
        end
        // WAIT entered at cycle 5; rvalid withheld -> timeout after 4 cycles
        tick();
        tick();
        tick();
        n_checks++;
        if (rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_early: rsp_valid=%b expected 0", rsp_valid);
        end
        tick();
        n_checks++;
        if ({rsp_valid, rsp_err, rsp_data} !== {2'b11, 32'h0}) begin
            n_fail++;
            $display("FAIL wait_timeout: valid=%b err=%b data=%h expected 1 1 0", rsp_valid, rsp_err, rsp_data);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        issue(`LSU_OPCODE_LW, 32'h0000_0400, 32'h0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        // now in WAIT
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({mem_req, rsp_valid, req_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL reset_mid: req=%b valid=%b ready=%b expected 0 0 1", mem_req, rsp_valid, req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        // late rvalid for the discarded load must not produce a response
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        tick();
        mem_rvalid = 1'b0;
        n_checks++;
        if ({rsp_valid, req_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_discard: valid=%b ready=%b expected 0 1", rsp_valid, req_ready);
        end
        issue(`LSU_OPCODE_SW, 32'h0000_0100, 32'h0BAD_F00D);
        mem_gnt = 1'b1;
        tick();
        mem_gnt = 1'b0;
        n_checks++;
        if ({rsp_valid, rsp_err, rsp_data} !== {2'b10, 32'h0}) begin
            n_fail++;
            $display("FAIL reset_then_sw: valid=%b err=%b data=%h expected 1 0 0", rsp_valid, rsp_err, rsp_data);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_misalign();
`ifdef LSU_MISALIGN_TRAP_EN
        issue(`LSU_OPCODE_LW, 32'h0000_0102, 32'h0);
        n_checks++;
        if ({mem_req, rsp_valid, misalign, rsp_err, rsp_data} !== {4'b0110, 32'h0}) begin
            n_fail++;
            $display("FAIL misalign_trap: req=%b valid=%b mis=%b err=%b data=%h expected 0 1 1 0 0",
                     mem_req, rsp_valid, misalign, rsp_err, rsp_data);
        end
        tick();
        n_checks++;
        if ({mem_req, rsp_valid, misalign} !== 3'b011) begin
            n_fail++;
            $display("FAIL misalign_hold: req=%b valid=%b mis=%b expected 0 1 1", mem_req, rsp_valid, misalign);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        n_checks++;
        if ({misalign, rsp_valid, req_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL misalign_clear: mis=%b valid=%b ready=%b expected 0 0 1", misalign, rsp_valid, req_ready);
        end
`else
        issue(`LSU_OPCODE_LW, 32'h0000_0102, 32'h0);
        n_checks++;
        if ({mem_req, misalign, mem_addr} !== {2'b10, 32'h0000_0100}) begin
            n_fail++;
            $display("FAIL misalign_lw_req: req=%b mis=%b addr=%h expected 1 0 00000100", mem_req, misalign, mem_addr);
        end
        mem_gnt = 1'b1;
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_F00D;
        tick();
        mem_rvalid = 1'b0;
        n_checks++;
        if ({rsp_valid, misalign, rsp_data} !== {2'b10, 32'hCAFE_F00D}) begin
            n_fail++;
            $display("FAIL misalign_lw_data: valid=%b mis=%b data=%h expected 1 0 cafef00d", rsp_valid, misalign, rsp_data);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        // LH at 0x103 is forced to 0x102 -> upper halfword, sign-extended
        issue(`LSU_OPCODE_LH, 32'h0000_0103, 32'h0);
        mem_gnt = 1'b1;
        tick();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h8001_1234;
        tick();
        mem_rvalid = 1'b0;
        n_checks++;
        if ({rsp_valid, rsp_data} !== {1'b1, 32'hFFFF_8001}) begin
            n_fail++;
            $display("FAIL misalign_lh_data: valid=%b data=%h expected 1 ffff8001", rsp_valid, rsp_data);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
`endif
    endtask

    task automatic test_back_to_back();
        int pulses;
        int reqs;
        pulses     = 0;
        reqs       = 0;
        mem_gnt    = 1'b1;
        rsp_ready  = 1'b1;
        lsu_opcode = `LSU_OPCODE_SW;
        addr       = 32'h0000_0500;
        wdata      = 32'h0000_0001;
        req_valid  = 1'b1;
        // accepts at cycles 0, 3, 6: responses land in cycles 2, 5, 8
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c == 9) begin
                req_valid  = 1'b0;
                lsu_opcode = `LSU_OPCODE_NONE;
                mem_gnt    = 1'b0;
                rsp_ready  = 1'b0;
            end
            pulses += int'(rsp_valid);
            reqs   += int'(mem_req);
        end
        n_checks++;
        if (pulses != 3) begin
            n_fail++;
            $display("FAIL b2b_rsp_count: got %0d expected 3", pulses);
        end
        n_checks++;
        if (reqs != 3) begin
            n_fail++;
            $display("FAIL b2b_req_count: got %0d expected 3", reqs);
        end
        tick();
        n_checks++;
        if ({mem_req, rsp_valid, req_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL b2b_idle: req=%b valid=%b ready=%b expected 0 0 1", mem_req, rsp_valid, req_ready);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        tick();
        tick();
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        test_reset();
        test_none_ignored();
        test_sw();
        test_sb_sh();
        test_loads();
        test_timeout();
        test_timeout_race();
        test_reset_mid();
        test_misalign();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case a scenario ever stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
